// File: rtl/sbox_pkg.sv
// +-----------------------------------------------------------------------+
// | sbox_pkg : shared types, sizes and substitution table for sbox_seq     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

package sbox_pkg;

  localparam int SBOX_W      = 4;
  localparam int NIB_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [SBOX_W-1:0] SBOX_TABLE [0:15] = '{
    4'hE, 4'h4, 4'hD, 4'h1, 4'h0, 4'hF, 4'h7, 4'h4,
    4'h4, 4'h1, 4'hE, 4'h8, 4'hF, 4'hC, 4'h8, 4'h2
  };

endpackage

`default_nettype wire

// File: rtl/sbox.sv
// +-----------------------------------------------------------------------+
// | sbox : 4-bit substitution cell, output registered (1-cycle latency)    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module sbox
  import sbox_pkg::*;
(
  input  logic              ck,
  input  logic [SBOX_W-1:0] nib_i,
  output logic [SBOX_W-1:0] nib_o
);

  logic [SBOX_W-1:0] nib_q;

  always_ff @(posedge ck) begin
    nib_q <= SBOX_TABLE[nib_i];
  end

  assign nib_o = nib_q;

endmodule

`default_nettype wire

// File: rtl/sbox_seq.sv
// +-----------------------------------------------------------------------+
// | sbox_seq : serialises a word through one shared sbox cell, LSB nibble  |
// | first. Optional completed-word counter: define SBOX_SEQ_CNT_EN.        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
`default_nettype none

module sbox_seq
  import sbox_pkg::*;
#(
  parameter int NIB  = NIB_DEFAULT,
  parameter int CNTW = 16
) (
  input  logic                ck,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*NIB-1:0]    in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*NIB-1:0]    out_data,
  output logic                busy
`ifdef SBOX_SEQ_CNT_EN
  , output logic [CNTW-1:0]   done_cnt
`endif
);

  localparam int W    = SBOX_W * NIB;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);

  state_t            state_q;
  logic [IDXW-1:0]   idx_q;
  logic [W-1:0]      word_q;
  logic              feed_vld_q;
  logic [W-1:0]      out_data_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [SBOX_W-1:0] cell_out;

  // Word is shifted right each FEED cycle, so the cell always sees bits [3:0].
  sbox u_sbox (
    .ck    (ck),
    .nib_i (word_q[SBOX_W-1:0]),
    .nib_o (cell_out)
  );

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      feed_vld_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // feed_vld_q marks the cycle the cell output belongs to a fed nibble;
      // results enter at the top so nibble 0 ends at the bottom after NIB captures.
      feed_vld_q <= (state_q == ST_FEED);
      if (feed_vld_q) begin
        out_data_q <= {cell_out, out_data_q[W-1:SBOX_W]};
      end
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            word_q  <= in_data;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_FEED;
          end
        end
        ST_FEED: begin
          word_q <= word_q >> SBOX_W;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

`ifdef SBOX_SEQ_CNT_EN
  logic [CNTW-1:0] done_cnt_q;

  always_ff @(posedge ck) begin
    if (rst) begin
      done_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      done_cnt_q <= done_cnt_q + 1'b1;
    end
  end

  assign done_cnt = done_cnt_q;
`else
  // Counter absent; CNTW kept so both builds share one parameter list.
  if (CNTW > 0) begin : g_no_cnt
  end
`endif

endmodule

`default_nettype wire

// File: doc/sbox_seq.md
# sbox_seq

Serialising controller that runs a 32-bit word through a single shared 4-bit `sbox` cell, one nibble per clock. It accepts a word on a valid/ready input, sequences nibbles 0..7 (LSB first) into the cell and compensates for the cell's one-cycle registered latency. It then reassembles the substituted word and holds it on a valid/ready output. It sits between the key/round datapath and the substitution layer, replacing eight parallel S-box instances with one.

## Interface
- `NIB`, default 8: nibbles per word; data width is 4*NIB.
- `CNTW`, default 16: width of the completed-word counter (used only with `SBOX_SEQ_CNT_EN`).

Ports:
- `ck`  in  1  clock, all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  input word offered.
- `in_ready`  out  1  controller can accept a word.
- `in_data`  in  4*NIB  word to substitute.
- `out_valid`  out  1  substituted word available.
- `out_ready`  in  1  consumer takes the word.
- `out_data`  out  4*NIB  substituted word.
- `busy`  out  1  high in FEED, DRAIN and DONE.
- `done_cnt`  out  CNTW  words delivered (only with `SBOX_SEQ_CNT_EN`).

## Operation
- States: IDLE, FEED, DRAIN, DONE.
  - IDLE → FEED on `in_valid && in_ready`. The word is latched and `idx` is set to 0.
  - FEED: drive nibble `idx` into the cell and increment `idx`. When `idx == NIB-1`, go to DRAIN.
  - DRAIN: one cycle to capture the last cell output. Then go to DONE.
  - DONE: hold the output. On `out_valid && out_ready`, go to IDLE.
- Result capture: the cell output for nibble k is written into result bits [4k+3:4k] on the cycle after nibble k was driven. A delayed index/valid register tracks this.
- Substitution table, input → output: 0→14, 1→4, 2→13, 3→1, 4→0, 5→15, 6→7, 7→4, 8→4, 9→1, 10→14, 11→8, 12→15, 13→12, 14→8, 15→2.
- `in_ready` equals (state==IDLE && !rst). It is a combinational decode of the state register. `in_valid` is ignored outside IDLE.
- `out_data` is registered and stable for the whole time `out_valid` is high, regardless of `in_*`.
- `out_data` is don't-care when `out_valid` is low. It is zeroed on reset.
- Reset values: state IDLE, `out_valid` 0, `out_data` 0, `busy` 0, `done_cnt` 0. `in_ready` is 0 while `rst` is high and 1 in the first cycle after `rst` is deasserted.
- Reset mid-operation (any state): the word is discarded and no partial result is ever presented. Any output of the cell still in flight is ignored.
- Simultaneous `rst` and handshake: reset wins, and `done_cnt` does not increment.

## Timing
- Input handshake at edge E.
- FEED covers the cycles after edges E..E+NIB-1. DRAIN is the cycle after edge E+NIB.
- `out_valid` rises after edge E+NIB+1. Latency is 9 cycles for NIB=8.
- With `out_ready` held at 1, the output handshake occurs at edge E+10 and `in_ready` is high after it. The next accept can be at edge E+11, giving a minimum period of 11 cycles.
- Backpressure: DONE persists for any number of cycles while `out_ready` is 0.

## Configuration
- `SBOX_SEQ_CNT_EN` defined:
  - `done_cnt` port exists.
  - It increments by 1 on each output handshake and wraps modulo 2^CNTW.
  - It is cleared by `rst`.
- Not defined: port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `sbox_pkg`:
  - State enum (IDLE, FEED, DRAIN, DONE).
  - Constants `SBOX_W = 4` and default `NIB`.
  - The 16-entry substitution table as a constant array, used by the bench model.
- One sub-module: the existing `sbox` cell (4-bit in, registered 4-bit out, clock `ck`, one cycle of latency). It is instantiated once.

## Test plan
- Reset, then `in_data` = 0x00000000 → `out_data` = 0xEEEEEEEE, with `out_valid` exactly 9 cycles after accept.
- `in_data` = 0x76543210 → 0x47F01D4E.
- `in_data` = 0xFEDCBA98 → 0x28CF8E14.
- Backpressure: hold `out_ready` = 0 for 20 cycles while toggling `in_valid` with a different word.
  - `in_ready` stays 0 throughout.
  - `out_data` stays stable.
  - After `out_ready`, the next word is accepted and its result is correct.
- Assert `rst` during FEED at `idx` = 4 → next cycle `out_valid` = 0, `busy` = 0 and `in_ready` = 1 after release. A following word 0x00000000 gives 0xEEEEEEEE.
- With `SBOX_SEQ_CNT_EN`, run 3 back-to-back words with `out_ready` = 1 → `done_cnt` = 3 and an 11-cycle accept period. Preload CNTW=4 and run 17 words → `done_cnt` wraps to 1.
